// File: rtl/bcd_entry_pkg.sv
// Shared types and constants for the front-panel BCD operand entry path.
package bcd_entry_pkg;

  typedef enum logic {COLLECT, HOLD} entry_state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/rise_edge_detect.sv
// Single-cycle pulse on a rising edge of d. The history register's reset value is a
// parameter so that a level already high at reset release can be treated as "seen".
module rise_edge_detect #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic pulse
);

  logic d_q;

  // History of d for edge detection; not affected by any synchronous abort.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_q <= RESET_VAL;
    end else begin
      d_q <= d;
    end
  end

  assign pulse = d & ~d_q;

endmodule

// File: rtl/bcd_operand_collector.sv
// Collects NUM_OPERANDS decimal operands of NUM_DIGITS BCD digits each, MSD first, converting
// to binary as digits arrive, then holds them with a valid/ack handshake for the adder.
module bcd_operand_collector
  import bcd_entry_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 3,
  parameter int unsigned NUM_OPERANDS = 2,
  localparam int unsigned BIN_W       = $clog2(10 ** NUM_DIGITS),
  localparam int unsigned OP_IDX_W    = $clog2(NUM_OPERANDS) + 1,
  localparam int unsigned DIG_IDX_W   = $clog2(NUM_DIGITS) + 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [3:0]                      dip_switch,
  input  logic                            input_ready,
  input  logic                            clear,
  input  logic                            operand_ack,
  output logic [NUM_OPERANDS*BIN_W-1:0]   operands_out,
  output logic                            operand_valid,
  output logic [OP_IDX_W-1:0]             operand_index,
  output logic [DIG_IDX_W-1:0]            digit_index,
  output logic                            digit_error
);

  localparam logic [OP_IDX_W-1:0]  LAST_OP  = OP_IDX_W'(NUM_OPERANDS - 1);
  localparam logic [DIG_IDX_W-1:0] LAST_DIG = DIG_IDX_W'(NUM_DIGITS - 1);

  bcd_digit_t             digit;
  logic                   cap;
  entry_state_t           state_q;
  logic [BIN_W-1:0]       acc_q [NUM_OPERANDS];
  logic [OP_IDX_W-1:0]    op_idx_q;
  logic [DIG_IDX_W-1:0]   dig_idx_q;
  logic                   valid_q;
  logic                   err_q;
  logic [BIN_W-1:0]       acc_sel;
  logic [BIN_W-1:0]       acc_next;

  assign digit = dip_switch;

  // History resets high so a strobe held across reset release is not a capture.
  rise_edge_detect #(
    .RESET_VAL(1'b1)
  ) u_cap_edge (
    .clk  (clk),
    .reset(reset),
    .d    (input_ready),
    .pulse(cap)
  );

  // Pick the accumulator being entered and form acc*10 + digit with shifts only.
  // Intermediate wrap is harmless: the true result always fits in BIN_W.
  always_comb begin
    acc_sel = '0;
    for (int k = 0; k < int'(NUM_OPERANDS); k++) begin
      if (op_idx_q == OP_IDX_W'(k)) begin
        acc_sel = acc_q[k];
      end
    end
    acc_next = (acc_sel << 3) + (acc_sel << 1) + BIN_W'(digit);
  end

  // Entry FSM, index counters, accumulators and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= COLLECT;
      op_idx_q  <= '0;
      dig_idx_q <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      for (int k = 0; k < int'(NUM_OPERANDS); k++) begin
        acc_q[k] <= '0;
      end
    end else begin
      err_q <= 1'b0;
      if (clear) begin
        state_q   <= COLLECT;
        op_idx_q  <= '0;
        dig_idx_q <= '0;
        valid_q   <= 1'b0;
        for (int k = 0; k < int'(NUM_OPERANDS); k++) begin
          acc_q[k] <= '0;
        end
      end else begin
        unique case (state_q)
          COLLECT: begin
            if (cap) begin
              if (digit <= BCD_MAX) begin
                for (int k = 0; k < int'(NUM_OPERANDS); k++) begin
                  if (op_idx_q == OP_IDX_W'(k)) begin
                    acc_q[k] <= acc_next;
                  end
                end
                if (dig_idx_q == LAST_DIG) begin
                  dig_idx_q <= '0;
                  if (op_idx_q == LAST_OP) begin
                    state_q <= HOLD;
                    valid_q <= 1'b1;
                  end else begin
                    op_idx_q <= op_idx_q + 1'b1;
                  end
                end else begin
                  dig_idx_q <= dig_idx_q + 1'b1;
                end
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          HOLD: begin
            // Strobes are dropped here; only the ack (or clear) leaves HOLD.
            if (operand_ack) begin
              state_q   <= COLLECT;
              op_idx_q  <= '0;
              dig_idx_q <= '0;
              valid_q   <= 1'b0;
              for (int k = 0; k < int'(NUM_OPERANDS); k++) begin
                acc_q[k] <= '0;
              end
            end
          end
          default: state_q <= COLLECT;
        endcase
      end
    end
  end

  // Flatten accumulators onto the output bus; partial values show through during entry.
  always_comb begin
    operands_out = '0;
    for (int k = 0; k < int'(NUM_OPERANDS); k++) begin
      operands_out[k*BIN_W +: BIN_W] = acc_q[k];
    end
  end

  assign operand_valid = valid_q;
  assign operand_index = op_idx_q;
  assign digit_index   = dig_idx_q;
  assign digit_error   = err_q;

endmodule
